// File: rtl/sub_pkg.sv
// Shared constants and helpers for the pipelined subtractor.
// The token layout depends on WIDTH, so the struct itself is declared inside sub32_pipe.
package sub_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 4;

    // Signed overflow of a - b: operands differ in sign and the result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the building block of each subtractor slice.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/sub_slice.sv
// SLICE-bit ripple adder computing a + nb + cin; one instance resolves one pipeline stage.
module sub_slice #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] nb_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    logic [SLICE:0] carry;

    assign carry[0] = cin_i;
    assign cout_o   = carry[SLICE];

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a_i   (a_i[i]),
            .b_i   (nb_i[i]),
            .cin_i (carry[i]),
            .sum_o (sum_o[i]),
            .cout_o(carry[i+1])
        );
    end

endmodule

// File: rtl/sub32_pipe.sv
// Pipelined WIDTH-bit subtractor, one SLICE per stage, valid/ready on both sides.
// Operands shift right as slices are consumed; finished diff bits shift in from the top.
module sub32_pipe
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0 || STAGES < 2) begin : g_bad_params
        $error("sub32_pipe: WIDTH must be a multiple of STAGES and STAGES >= 2");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] nb_rem;
        logic [WIDTH-1:0] diff_lo;
        logic             carry;
        logic             a_msb;
        logic             b_msb;
    } token_t;

    token_t             tok_in  [STAGES];
    token_t             tok_out [STAGES-1];
    token_t             tok_q   [STAGES-1];
    logic [SLICE-1:0]   sum     [STAGES];
    logic [STAGES-1:0]  cout;
    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  adv;
    logic [STAGES-1:0]  load;
    logic               in_fire;

    logic [WIDTH-1:0]   diff_d, diff_q;
    logic               borrow_q, overflow_q, zero_q;

    // Advance chain runs from the output back to the input, so ready_i reaches ready_o
    // combinationally and bubbles are squeezed out during a downstream stall.
    assign adv[STAGES-1] = v_q[STAGES-1] & ready_i;
    for (genvar s = 0; s < STAGES - 1; s++) begin : g_adv
        assign adv[s] = v_q[s] & (~v_q[s+1] | adv[s+1]);
    end

    assign ready_o = ~v_q[0] | adv[0];
    assign in_fire = valid_i & ready_o;
    assign load    = {adv[STAGES-2:0], in_fire};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign tok_in[0] = '{a_rem:   a_i,
                                 nb_rem:  ~b_i,
                                 diff_lo: '0,
                                 carry:   ~borrow_i,
                                 a_msb:   a_i[WIDTH-1],
                                 b_msb:   b_i[WIDTH-1]};
        end else begin : g_link
            assign tok_in[k] = tok_q[k-1];
        end

        sub_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a_i   (tok_in[k].a_rem[SLICE-1:0]),
            .nb_i  (tok_in[k].nb_rem[SLICE-1:0]),
            .cin_i (tok_in[k].carry),
            .sum_o (sum[k]),
            .cout_o(cout[k])
        );

        if (k < STAGES - 1) begin : g_fwd
            assign tok_out[k] = '{a_rem:   tok_in[k].a_rem >> SLICE,
                                  nb_rem:  tok_in[k].nb_rem >> SLICE,
                                  diff_lo: {sum[k], tok_in[k].diff_lo[WIDTH-1:SLICE]},
                                  carry:   cout[k],
                                  a_msb:   tok_in[k].a_msb,
                                  b_msb:   tok_in[k].b_msb};
        end
    end

    assign diff_d = {sum[STAGES-1], tok_in[STAGES-1].diff_lo[WIDTH-1:SLICE]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q        <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            for (int s = 0; s < STAGES - 1; s++) begin
                tok_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    v_q[s] <= 1'b1;
                end else if (adv[s]) begin
                    v_q[s] <= 1'b0;
                end
            end
            for (int s = 0; s < STAGES - 1; s++) begin
                if (load[s]) begin
                    tok_q[s] <= tok_out[s];
                end
            end
            if (load[STAGES-1]) begin
                diff_q     <= diff_d;
                borrow_q   <= ~cout[STAGES-1];
                overflow_q <= sub_overflow(tok_in[STAGES-1].a_msb, tok_in[STAGES-1].b_msb,
                                           diff_d[WIDTH-1]);
                zero_q     <= (diff_d == '0);
            end
        end
    end

    assign valid_o    = v_q[STAGES-1];
    assign diff_o     = diff_q;
    assign borrow_o   = borrow_q;
    assign overflow_o = overflow_q;
    assign zero_o     = zero_q;

endmodule
